rv32_mem_access: RTL
====================

// Module: rv32_mem_access
// PURPOSE
//  Memory stage, directly downstream of the execute stage. Consumes execute's registered outputs:
//  - runs one data-bus load/store per instruction, with byte-lane steering and load sign/zero extension;
//  - resolves the branch from branch_op and the ALU result;
//  - registers rd/rd_write/rd_value for writeback and for execute's forwarding path.
// PARAMETERS
//  WAIT_LIMIT  255  max cycles in WAIT before the access is abandoned as a bus error; 0 = no limit
// PORTS
//  clk                   in   1   clock; all state on posedge
//  reset                 in   1   asynchronous, active-high reset
//  stall_in              in   1   hazard: hold stage outputs
//  flush_in              in   1   hazard: squash the instruction now in this stage
//  mem_read_in           in   1   load
//  mem_write_in          in   1   store
//  mem_width_in          in   2   BYTE/HALF/WORD
//  mem_zero_extend_in    in   1   1 = zero-extend loads, 0 = sign-extend
//  branch_op_in          in   2   NEVER/ZERO/NON_ZERO/ALWAYS
//  branch_pc_in          in   32  branch target
//  rd_in                 in   5   destination register
//  rd_write_in           in   1   destination write enable
//  result_in             in   32  ALU result; effective address for loads/stores
//  rs2_value_in          in   32  store data
//  dbus_read_value_in    in   32  bus read data, valid when dbus_ready_in=1
//  dbus_ready_in         in   1   bus completes the current request this cycle
//  dbus_address_out      out  32  word-aligned address {addr[31:2],2'b00}
//  dbus_read_out         out  1   read request
//  dbus_write_out        out  1   write request
//  dbus_write_mask_out   out  4   byte enables
//  dbus_write_value_out  out  32  lane-replicated store data
//  busy_out              out  1   stage cannot complete; hazard stalls upstream
//  branch_taken_out      out  1   combinational branch decision
//  branch_pc_out         out  32  combinational, = branch_pc_in
//  rd_out                out  5   to writeback
//  rd_write_out          out  1   to writeback
//  rd_value_out          out  32  to writeback
//  fault_out             out  1   registered 1-cycle pulse: misaligned access or bus timeout
// BEHAVIOUR
//  Reset: all registered outputs 0; FSM in IDLE; request regs 0; dbus_* outputs 0.
//  Misaligned: HALF with addr[0]=1, or WORD with addr[1:0]!=0. No bus request is issued;
//  on the output update rd_write_out=0 and fault_out=1.
//  access = (mem_read_in|mem_write_in) & ~misaligned & ~flush_in.
//  Write mask: BYTE 4'b0001<<a[1:0]; HALF 4'b0011<<{a[1],1'b0}; WORD 4'b1111.
//  Write data: BYTE {4{rs2[7:0]}}; HALF {2{rs2[15:0]}}; WORD rs2.
//  Load data: shift read data right by 8*lane, then sign- or zero-extend from bit 7 (BYTE) or bit 15 (HALF).
//  Branch decision: NEVER 0; ZERO result_in==0; NON_ZERO result_in!=0; ALWAYS 1. Forced 0 while flush_in.
//  FSM states:
//  - IDLE: bus driven combinationally from the inputs when access=1.
//    - dbus_ready_in=1: zero-wait completion. Go to DONE if stall_in, else stay IDLE.
//    - dbus_ready_in=0: latch address, mask, data, read/write into request regs; go to WAIT; busy_out=1.
//  - WAIT: bus driven from the request regs; busy_out=1; wait counter increments.
//    - ready: capture read data; go to DONE if stall_in, else IDLE.
//    - flush_in without ready: go to ABORT.
//    - counter reaches WAIT_LIMIT (nonzero): drop the request, fault_out=1, rd_write_out=0, go to IDLE.
//  - ABORT: request held until ready (a bus cycle is never withdrawn); result discarded;
//    busy_out=1; then IDLE with a bubble output.
//  - DONE: bus idle; busy_out=0; captured load data held. When stall_in falls, outputs load, then IDLE.
//    A store is never re-issued.
//  Output update happens when ~stall_in & ~busy_out:
//  - rd_out <= rd_in;
//  - rd_write_out <= rd_write_in & ~flush_in & ~fault;
//  - rd_value_out <= load ? extended data : result_in.
//  Otherwise all outputs hold.
//  Latency: zero-wait access and non-memory instructions take 1 cycle; each wait state adds 1 cycle.
//  Simultaneous ready and flush in WAIT: transaction complete, output is a bubble, go to IDLE.
//  Reset mid-WAIT/ABORT: bus outputs drop to 0 immediately. The bus side must tolerate this.
// STRUCTURE
//  Shared header: width codes (BYTE=0, HALF=1, WORD=2), branch-op codes, FSM state enum.
//  One sub-module, rv32_mem_align: combinational mask/data steering and load extension.
//  The FSM, request regs, wait counter and output regs live in the top module.
// TESTING
//  1. WORD store, addr 0x104, rs2=0xDEADBEEF, ready same cycle
//     -> mask 1111, addr 0x104, busy_out never 1, rd_write_out 0.
//  2. BYTE load, addr 0x203, zero_ext=0, read data 0x80FFFFFF, ready after 3 cycles
//     -> busy_out high 3 cycles, rd_value_out 0xFFFFFF80; repeat with zero_ext=1 -> 0x00000080.
//  3. HALF store to 0x11, and WORD load from 0x12
//     -> no dbus request, fault_out pulses once, rd_write_out 0.
//  4. Flush during WAIT of a store; ready 2 cycles later
//     -> write request held steady until ready, then a bubble output, FSM back in IDLE.
//  5. ready arrives while stall_in=1 for 4 cycles
//     -> single bus beat, DONE held, load value appears after stall_in drops, no second request.
//  6. WAIT_LIMIT=4, ready never asserted
//     -> request dropped after 4 wait cycles, fault_out pulse; assert reset mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/rv32_mem_access_pkg.sv
// Shared codes and types for the rv32 memory stage.
package rv32_mem_access_pkg;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    BR_NEVER    = 2'd0,
    BR_ZERO     = 2'd1,
    BR_NON_ZERO = 2'd2,
    BR_ALWAYS   = 2'd3
  } branch_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        read;
    logic        write;
    logic [1:0]  width;
    logic        zext;
  } req_t;

  function automatic logic misaligned(
    input logic [1:0] width,
    input logic [1:0] lane
  );
    return (width == W_HALF && lane[0]) ||
           (width == W_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/rv32_mem_align.sv
// Byte-lane steering for stores and lane extraction
// plus sign/zero extension for loads.
module rv32_mem_align
  import rv32_mem_access_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  lane,
  input  logic        zext,
  input  logic [31:0] store_value,
  input  logic [31:0] read_value,
  output logic [3:0]  mask,
  output logic [31:0] write_value,
  output logic [31:0] load_value
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = read_value >> {lane, 3'b000};
    mask        = 4'b1111;
    write_value = store_value;
    load_value  = shifted;
    unique case (width)
      W_BYTE: begin
        mask        = 4'b0001 << lane;
        write_value = {4{store_value[7:0]}};
        load_value  = {{24{~zext & shifted[7]}},
                       shifted[7:0]};
      end
      W_HALF: begin
        mask        = 4'b0011 << {lane[1], 1'b0};
        write_value = {2{store_value[15:0]}};
        load_value  = {{16{~zext & shifted[15]}},
                       shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_mem_access.sv
// Memory stage: data-bus access FSM, branch
// resolution and writeback/forwarding registers.
module rv32_mem_access
  import rv32_mem_access_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [1:0]  branch_op_in,
  input  logic [31:0] branch_pc_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] dbus_read_value_in,
  input  logic        dbus_ready_in,
  output logic [31:0] dbus_address_out,
  output logic        dbus_read_out,
  output logic        dbus_write_out,
  output logic [3:0]  dbus_write_mask_out,
  output logic [31:0] dbus_write_value_out,
  output logic        busy_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_pc_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        fault_out
);

  localparam int CW =
    (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
  localparam logic LIMITED = (WAIT_LIMIT != 0);

  state_e      state, state_nxt;
  req_t        req;
  logic [CW-1:0] cnt;
  logic [31:0] data_q;
  logic        pend_read, pend_kill, pend_fault;

  logic        mem, mis_fault, access, timeout;
  logic        busy, upd, latch;
  logic        nxt_wr, nxt_fault;
  logic [31:0] nxt_val;
  logic        cap, cap_read, cap_kill, cap_fault;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_addr, bus_wval;
  logic [3:0]  bus_mask;
  logic        taken;

  logic [1:0]  a_width, a_lane;
  logic        a_zext;
  logic [3:0]  al_mask;
  logic [31:0] al_wval, al_load;

  assign mem = mem_read_in | mem_write_in;
  assign mis_fault = mem & ~flush_in &
    misaligned(mem_width_in, result_in[1:0]);
  assign access = mem & ~flush_in &
    ~misaligned(mem_width_in, result_in[1:0]);

  // In-flight accesses extend with the latched shape
  assign a_width = (state == S_IDLE) ?
    mem_width_in : req.width;
  assign a_lane = (state == S_IDLE) ?
    result_in[1:0] : req.addr[1:0];
  assign a_zext = (state == S_IDLE) ?
    mem_zero_extend_in : req.zext;

  rv32_mem_align u_align (
    .width       (a_width),
    .lane        (a_lane),
    .zext        (a_zext),
    .store_value (rs2_value_in),
    .read_value  (dbus_read_value_in),
    .mask        (al_mask),
    .write_value (al_wval),
    .load_value  (al_load)
  );

  assign timeout = LIMITED & (state == S_WAIT) &
    ~dbus_ready_in & ~flush_in & (cnt == LAST);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    upd       = 1'b0;
    latch     = 1'b0;
    nxt_wr    = 1'b0;
    nxt_val   = result_in;
    nxt_fault = 1'b0;
    cap       = 1'b0;
    cap_read  = 1'b0;
    cap_kill  = 1'b0;
    cap_fault = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_mask  = '0;
    bus_wval  = '0;
    unique case (state)
      S_IDLE: begin
        if (access) begin
          bus_rd   = mem_read_in;
          bus_wr   = mem_write_in;
          bus_addr = {result_in[31:2], 2'b00};
          bus_mask = mem_write_in ? al_mask : 4'b0000;
          bus_wval = mem_write_in ? al_wval : '0;
          if (dbus_ready_in) begin
            if (mem_read_in) nxt_val = al_load;
            if (stall_in) begin
              state_nxt = S_DONE;
              cap       = 1'b1;
              cap_read  = mem_read_in;
            end
          end else begin
            busy      = 1'b1;
            latch     = 1'b1;
            state_nxt = S_WAIT;
          end
        end
        upd       = ~stall_in & ~busy;
        nxt_wr    = rd_write_in & ~flush_in & ~mis_fault;
        nxt_fault = mis_fault;
      end
      S_WAIT, S_ABORT: begin
        bus_rd   = req.read;
        bus_wr   = req.write;
        bus_addr = {req.addr[31:2], 2'b00};
        bus_mask = req.mask;
        bus_wval = req.wdata;
        if (dbus_ready_in) begin
          upd       = ~stall_in;
          if (req.read) nxt_val = al_load;
          nxt_wr    = (state == S_WAIT) &
                      rd_write_in & ~flush_in;
          cap       = stall_in;
          cap_read  = req.read;
          cap_kill  = (state == S_ABORT) | flush_in;
          state_nxt = stall_in ? S_DONE : S_IDLE;
        end else if (state == S_WAIT && flush_in) begin
          busy      = 1'b1;
          state_nxt = S_ABORT;
        end else if (timeout) begin
          upd       = ~stall_in;
          nxt_fault = 1'b1;
          cap       = stall_in;
          cap_fault = 1'b1;
          state_nxt = stall_in ? S_DONE : S_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      S_DONE: begin
        // Result is parked here; the bus stays idle
        upd       = ~stall_in;
        nxt_val   = pend_read ? data_q : result_in;
        nxt_wr    = rd_write_in & ~flush_in &
                    ~pend_kill & ~pend_fault;
        nxt_fault = pend_fault & ~flush_in;
        if (!stall_in) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (branch_op_in)
      BR_ZERO:     taken = (result_in == '0);
      BR_NON_ZERO: taken = (result_in != '0);
      BR_ALWAYS:   taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

  assign branch_taken_out = taken & ~flush_in;
  assign branch_pc_out    = branch_pc_in;

  assign busy_out             = busy & ~reset;
  assign dbus_read_out        = bus_rd & ~reset;
  assign dbus_write_out       = bus_wr & ~reset;
  assign dbus_address_out     = reset ? '0 : bus_addr;
  assign dbus_write_mask_out  = reset ? '0 : bus_mask;
  assign dbus_write_value_out = reset ? '0 : bus_wval;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      req          <= '0;
      cnt          <= '0;
      data_q       <= '0;
      pend_read    <= 1'b0;
      pend_kill    <= 1'b0;
      pend_fault   <= 1'b0;
      rd_out       <= '0;
      rd_write_out <= 1'b0;
      rd_value_out <= '0;
      fault_out    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        req.addr  <= result_in;
        req.wdata <= mem_write_in ? al_wval : '0;
        req.mask  <= mem_write_in ? al_mask : 4'b0000;
        req.read  <= mem_read_in;
        req.write <= mem_write_in;
        req.width <= mem_width_in;
        req.zext  <= mem_zero_extend_in;
        cnt       <= '0;
      end else if (state == S_WAIT &&
                   state_nxt == S_WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (cap) begin
        data_q     <= al_load;
        pend_read  <= cap_read;
        pend_kill  <= cap_kill;
        pend_fault <= cap_fault;
      end
      fault_out <= upd & nxt_fault;
      if (upd) begin
        rd_out       <= rd_in;
        rd_write_out <= nxt_wr;
        rd_value_out <= nxt_val;
      end
    end
  end

endmodule
